conv_weights_ddr_rd_issuer: RTL
===============================

// Module: conv_weights_ddr_rd_issuer
// PURPOSE
// Downstream of the conv weight-load controller. Takes one DDR read command (word base address and
// length), splits it into per-word MIG read requests with app_rdy handshaking, and bounds outstanding
// requests. Returns read words to the controller as ddr_rd_data_valid/ddr_rd_data, one cycle after MIG.
// Raises ddr_cmd_ready only when the previous command has fully drained.
// PARAMETERS
// DATA_W          512  width of one DDR word (MIG app_rd_data width)
// ADDR_W          29   MIG app_addr width
// ADR_STRIDE_LOG2 3    app_addr = word_adr << ADR_STRIDE_LOG2 (512b word = 8 x 64b beats)
// MAX_OUTSTANDING 64   max issued-but-not-returned reads; power of 2, >= 2
// PORTS
// clk                         in   1       single clock, all logic rising-edge
// reset                       in   1       asynchronous, active-low; asserted when 0
// load_weights_ddr_base_adr   in   32      first word address of command
// load_weights_ddr_length     in   16      words in command, 1..65535
// valid_load_weights_ddr_cmd  in   1       command strobe, sampled only while ddr_cmd_ready=1
// ddr_cmd_ready               out  1       1 = IDLE, command accepted this cycle if strobed
// app_en                      out  1       MIG request valid
// app_cmd                     out  3       constant 3'b001 (read)
// app_addr                    out  ADDR_W  MIG byte/beat address
// app_rdy                     in   1       MIG accepts request when app_en && app_rdy
// app_rd_data                 in   DATA_W  MIG read data
// app_rd_data_valid           in   1       MIG read data valid
// ddr_rd_data_valid           out  1       registered copy of accepted app_rd_data_valid
// ddr_rd_data                 out  DATA_W  registered copy of app_rd_data
// cmd_busy                    out  1       ~ddr_cmd_ready
// err_len_zero                out  1       1-cycle pulse: command with length 0 dropped
// err_stray_data              out  1       1-cycle pulse: read data arrived while IDLE, dropped
// BEHAVIOUR
// - Reset (reset=0): state IDLE; ddr_cmd_ready=1, app_en=0, app_addr=0, ddr_rd_data_valid=0,
//   ddr_rd_data=0, err_*=0, issued/returned/outstanding counters=0. Takes effect immediately, any state.
// - States: IDLE, ISSUE, DRAIN.
// - IDLE: on valid && length!=0, latch base_adr, len; issued=0, returned=0; next ISSUE.
//   On valid && length==0: stay IDLE, err_len_zero=1 next cycle.
// - ISSUE: app_en=1 iff outstanding<MAX_OUTSTANDING. app_addr=((base+issued)<<ADR_STRIDE_LOG2),
//   truncated to ADDR_W; 32-bit address wraps silently. app_en/app_addr held stable until app_rdy.
//   On app_en&&app_rdy: issued++. When last word (issued==len-1) is accepted: next DRAIN, or
//   IDLE if returned (incl. this cycle's return) already == len.
// - DRAIN: app_en=0; next IDLE when returned reaches len (transition on the final return cycle).
// - Return path (ISSUE/DRAIN): app_rd_data_valid -> returned++, ddr_rd_data_valid=1 and
//   ddr_rd_data=app_rd_data the following cycle (latency 1, no backpressure, no data reordering).
// - outstanding = issued - returned; +1 on accepted request, -1 on return, both same cycle -> unchanged.
// - app_rd_data_valid in IDLE: no ddr_rd_data_valid; err_stray_data=1 next cycle.
// - ddr_cmd_ready combinational = (state==IDLE); first app_en no earlier than the cycle after accept.
// - len and returned are 16 bit; no return beyond len is expected within a command; extra
//   returns after len count as stray once IDLE.
// TESTING
// 1 base=0x100, len=4, app_rdy=1, 5-cycle data latency -> app_addr 0x800,0x808,0x810,0x818 on 4 consecutive
//   cycles; 4 ddr_rd_data_valid pulses; ddr_cmd_ready=1 the cycle after 4th app_rd_data_valid.
// 2 len=32, app_rdy toggling 1/0 -> app_addr held while app_rdy=0; exactly 32 accepted requests, no gaps
//   or repeats in address sequence.
// 3 MAX_OUTSTANDING=64, len=100, data withheld -> app_en drops after 64 accepts; resumes one-for-one
//   as data returns; total 100 returns then IDLE.
// 4 valid with len=0 -> err_len_zero pulse, ddr_cmd_ready stays 1, no app_en.
// 5 reset=0 mid-ISSUE (issued=10 of 32) -> app_en=0 and ddr_cmd_ready=1 immediately; pending returns
//   after release -> err_stray_data pulses, no ddr_rd_data_valid.
// 6 base=0xFFFFFFFF, len=2 -> second app_addr = (0<<3) truncated, i.e. 0; wrap without error.

Source files
------------

// File: rtl/conv_weights_ddr_rd_issuer.sv
// Conv weight DDR read issuer: splits one word-range read command into per-word
// MIG read requests, bounds the number in flight, and forwards returned words.
module conv_weights_ddr_rd_issuer #(
    parameter int unsigned DATA_W          = 512,
    parameter int unsigned ADDR_W          = 29,
    parameter int unsigned ADR_STRIDE_LOG2 = 3,
    parameter int unsigned MAX_OUTSTANDING = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       load_weights_ddr_base_adr,
    input  logic [15:0]       load_weights_ddr_length,
    input  logic              valid_load_weights_ddr_cmd,
    output logic              ddr_cmd_ready,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    input  logic              app_rdy,
    input  logic [DATA_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid,
    output logic              ddr_rd_data_valid,
    output logic [DATA_W-1:0] ddr_rd_data,
    output logic              cmd_busy,
    output logic              err_len_zero,
    output logic              err_stray_data
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned SH_W  = 32 + ADR_STRIDE_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         base_q, base_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         issued_q, issued_d;
    logic [15:0]         returned_q, returned_d;
    logic [OUT_W-1:0]    outst_q, outst_d;
    logic                app_en_q, app_en_d;
    logic [ADDR_W-1:0]   app_addr_q, app_addr_d;
    logic                rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                err_len_q, err_len_d;
    logic                err_stray_q, err_stray_d;
    logic                acc_c;
    logic                ret_c;
    logic [31:0]         adr_sum;

    // Next-state, counter and output computation
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        issued_d    = issued_q;
        returned_d  = returned_q;
        outst_d     = outst_q;
        rd_vld_d    = 1'b0;
        rd_data_d   = rd_data_q;
        err_len_d   = 1'b0;
        err_stray_d = 1'b0;
        adr_sum     = 32'd0;
        app_addr_d  = app_addr_q;

        acc_c = app_en_q && app_rdy;
        ret_c = app_rd_data_valid && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                err_stray_d = app_rd_data_valid;
                if (valid_load_weights_ddr_cmd) begin
                    if (load_weights_ddr_length != 16'd0) begin
                        base_d     = load_weights_ddr_base_adr;
                        len_d      = load_weights_ddr_length;
                        issued_d   = 16'd0;
                        returned_d = 16'd0;
                        outst_d    = '0;
                        state_d    = ST_ISSUE;
                    end else begin
                        err_len_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (acc_c) issued_d = issued_q + 16'd1;
                if (ret_c) returned_d = returned_q + 16'd1;
                if (acc_c && !ret_c) outst_d = outst_q + OUT_W'(1);
                if (!acc_c && ret_c) outst_d = outst_q - OUT_W'(1);
                if (acc_c && (issued_q == len_q - 16'd1)) begin
                    state_d = (returned_d == len_q) ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (ret_c) begin
                    returned_d = returned_q + 16'd1;
                    outst_d    = outst_q - OUT_W'(1);
                    if (returned_d == len_q) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ret_c) begin
            rd_vld_d  = 1'b1;
            rd_data_d = app_rd_data;
        end

        // Request is only presented while issuing and below the in-flight cap
        app_en_d = (state_d == ST_ISSUE) && (outst_d < OUT_W'(MAX_OUTSTANDING));
        if (state_d == ST_ISSUE) begin
            adr_sum    = base_d + 32'(issued_d);
            app_addr_d = ADDR_W'(SH_W'(adr_sum) << ADR_STRIDE_LOG2);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            base_q      <= 32'd0;
            len_q       <= 16'd0;
            issued_q    <= 16'd0;
            returned_q  <= 16'd0;
            outst_q     <= '0;
            app_en_q    <= 1'b0;
            app_addr_q  <= '0;
            rd_vld_q    <= 1'b0;
            rd_data_q   <= '0;
            err_len_q   <= 1'b0;
            err_stray_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            returned_q  <= returned_d;
            outst_q     <= outst_d;
            app_en_q    <= app_en_d;
            app_addr_q  <= app_addr_d;
            rd_vld_q    <= rd_vld_d;
            rd_data_q   <= rd_data_d;
            err_len_q   <= err_len_d;
            err_stray_q <= err_stray_d;
        end
    end

    assign ddr_cmd_ready     = (state_q == ST_IDLE);
    assign cmd_busy          = ~ddr_cmd_ready;
    assign app_cmd           = 3'b001;
    assign app_en            = app_en_q;
    assign app_addr          = app_addr_q;
    assign ddr_rd_data_valid = rd_vld_q;
    assign ddr_rd_data       = rd_data_q;
    assign err_len_zero      = err_len_q;
    assign err_stray_data    = err_stray_q;

endmodule
